control_unit: RTL and testbench

Finite-state controller for the 8-bit accumulator CPU. It sits directly upstream of `datapath`. It consumes the datapath's opcode (`IR`) and status (`Aeq0`, `Apos`) and produces every datapath control strobe. Each instruction runs through a fetch/decode/execute sequence. The block also handles the `IN` keypad handshake and halting.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/edge_detect.sv | 18 +
 rtl/control_unit.sv | 115 +++++++++++
 tb/tb_control_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, state encodings and A-source codes for the accumulator CPU
package cpu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_JZ     = 4'd8,
    S_JPOS   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector for an already-synchronised level
module edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute controller driving the accumulator datapath
module control_unit
  import cpu_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enter,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       Halt,
  output logic [3:0] State
);

  state_t state;
  logic   enter_rise;

  edge_detect u_enter_edge (
    .Clock (Clock),
    .Reset (Reset),
    .d     (Enter),
    .rise  (enter_rise)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_START;
    end else begin
      case (state)
        S_START:  state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (IR)
            OP_LOAD:  state <= S_LOAD;
            OP_STORE: state <= S_STORE;
            OP_ADD:   state <= S_ADD;
            OP_SUB:   state <= S_SUB;
            OP_IN:    state <= S_INPUT;
            OP_JZ:    state <= S_JZ;
            OP_JPOS:  state <= S_JPOS;
            default:  state <= S_HALT;
          endcase
        end
        // A held Enter never re-triggers; only a fresh rising edge releases IN.
        S_INPUT:  state <= enter_rise ? S_FETCH : S_INPUT;
        S_HALT:   state <= S_HALT;
        S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state <= S_FETCH;
        default:  state <= S_START;
      endcase
    end
  end

  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;
    case (state)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_DECODE: Meminst = 1'b1;
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = ASEL_RAM;
        Aload   = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      S_SUB: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      S_INPUT: begin
        Asel  = ASEL_IN;
        Aload = enter_rise;
      end
      // Untaken branch leaves PC at the value already incremented in FETCH.
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed table-driven bench for control_unit
module tb_control_unit;

  logic       Clock, Reset, Enter, Aeq0, Apos;
  logic [2:0] IR;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;

  control_unit dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enter   (Enter),
    .IR      (IR),
    .Aeq0    (Aeq0),
    .Apos    (Apos),
    .IRload  (IRload),
    .JMPmux  (JMPmux),
    .PCload  (PCload),
    .Meminst (Meminst),
    .MemWr   (MemWr),
    .Asel    (Asel),
    .Aload   (Aload),
    .Sub     (Sub),
    .Halt    (Halt),
    .State   (State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Control vector: {IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, Sub, Halt}
  localparam logic [9:0] C_NONE   = 10'b0000000000;
  localparam logic [9:0] C_FETCH  = 10'b1010000000;
  localparam logic [9:0] C_DECODE = 10'b0001000000;
  localparam logic [9:0] C_LOAD   = 10'b0001010100;
  localparam logic [9:0] C_STORE  = 10'b0001100000;
  localparam logic [9:0] C_ADD    = 10'b0001000100;
  localparam logic [9:0] C_SUB    = 10'b0001000110;
  localparam logic [9:0] C_INWAIT = 10'b0000001000;
  localparam logic [9:0] C_INRISE = 10'b0000001100;
  localparam logic [9:0] C_JTAKE  = 10'b0110000000;
  localparam logic [9:0] C_JSKIP  = 10'b0100000000;
  localparam logic [9:0] C_HALT   = 10'b0000000001;

  localparam logic [3:0] ST_START = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                         ST_LOAD = 4'd3, ST_STORE = 4'd4, ST_ADD = 4'd5,
                         ST_SUB = 4'd6, ST_INPUT = 4'd7, ST_JZ = 4'd8,
                         ST_JPOS = 4'd9, ST_HALT = 4'd10;

  typedef struct {
    logic [2:0] ir;
    logic       aeq0;
    logic       apos;
    logic [3:0] st;
    logic [9:0] ctrl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [9:0] ctrl_now();
    return {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt};
  endfunction

  task automatic check(input string name, input logic [3:0] st, input logic [9:0] ctrl);
    checks++;
    if (State !== st || ctrl_now() !== ctrl) begin
      failures++;
      $display("FAIL %s: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
               name, State, ctrl_now(), st, ctrl);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic add(input logic [2:0] ir, input logic aeq0, input logic apos,
                     input logic [3:0] st, input logic [9:0] ctrl);
    vec_t v;
    v.ir = ir; v.aeq0 = aeq0; v.apos = apos; v.st = st; v.ctrl = ctrl;
    vecs.push_back(v);
  endtask

  task automatic instr(input logic [2:0] ir, input logic aeq0, input logic apos,
                       input logic [3:0] st, input logic [9:0] ctrl);
    add(ir, aeq0, apos, ST_FETCH, C_FETCH);
    add(ir, aeq0, apos, ST_DECODE, C_DECODE);
    add(ir, aeq0, apos, st, ctrl);
  endtask

  initial begin
    add(3'b000, 1'b0, 1'b0, ST_START, C_NONE);
    instr(3'b010, 1'b0, 1'b0, ST_ADD,   C_ADD);
    instr(3'b011, 1'b0, 1'b0, ST_SUB,   C_SUB);
    instr(3'b001, 1'b0, 1'b0, ST_STORE, C_STORE);
    instr(3'b000, 1'b0, 1'b0, ST_LOAD,  C_LOAD);
    instr(3'b101, 1'b1, 1'b0, ST_JZ,    C_JTAKE);
    instr(3'b101, 1'b0, 1'b1, ST_JZ,    C_JSKIP);
    instr(3'b110, 1'b0, 1'b1, ST_JPOS,  C_JTAKE);
    instr(3'b110, 1'b1, 1'b0, ST_JPOS,  C_JSKIP);
    add(3'b100, 1'b0, 1'b0, ST_FETCH, C_FETCH);

    Reset = 1'b1; Enter = 1'b0; IR = 3'b000; Aeq0 = 1'b0; Apos = 1'b0;
    tick();
    tick();
    check("reset_held", ST_START, C_NONE);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      IR = vecs[i].ir; Aeq0 = vecs[i].aeq0; Apos = vecs[i].apos;
      #1;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl);
      tick();
    end

    // IN: wait with Enter low, then a single rise loads once
    check("in_decode", ST_DECODE, C_DECODE);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("in_wait%0d", k), ST_INPUT, C_INWAIT);
      tick();
    end
    Enter = 1'b1;
    #1;
    check("in_rise", ST_INPUT, C_INRISE);
    tick();
    check("in_fetch", ST_FETCH, C_FETCH);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("in_held%0d", k), ST_INPUT, C_INWAIT);
      tick();
    end
    Enter = 1'b0;
    #1;
    check("in_low", ST_INPUT, C_INWAIT);
    tick();
    Enter = 1'b1;
    #1;
    check("in_rise2", ST_INPUT, C_INRISE);
    tick();
    check("in_fetch2", ST_FETCH, C_FETCH);
    Enter = 1'b0;

    // Asynchronous reset mid-DECODE, Enter rising at release
    IR = 3'b111;
    tick();
    check("pre_reset_decode", ST_DECODE, C_DECODE);
    Reset = 1'b1;
    #1;
    check("async_reset", ST_START, C_NONE);
    tick();
    check("reset_hold2", ST_START, C_NONE);
    Reset = 1'b0;
    Enter = 1'b1;
    #1;
    check("release_start", ST_START, C_NONE);
    tick();
    check("first_fetch", ST_FETCH, C_FETCH);
    tick();
    check("halt_decode", ST_DECODE, C_DECODE);
    tick();
    for (int k = 0; k < 20; k++) begin
      IR = 3'(k);
      Enter = k[0];
      #1;
      check($sformatf("halt%0d", k), ST_HALT, C_HALT);
      tick();
    end
    Reset = 1'b1;
    #1;
    check("halt_reset", ST_START, C_NONE);
    Reset = 1'b0;
    tick();
    check("after_halt_fetch", ST_FETCH, C_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
